// File: rtl/sobel_pkg.sv
// Shared constants, width helper and window type for the grayscale Sobel edge stage.
package sobel_pkg;

    localparam int SOBEL_LAT = 4;

    // Pixel storage width of the window type; the top-level DW must not exceed it.
    localparam int SOBEL_PW = 8;

    function automatic int gw(input int dw);
        return dw + 3;
    endfunction

    // p[row][col]: row 0 is the oldest line (r-2), col 0 the oldest column (c-2).
    typedef struct packed {
        logic [2:0][2:0][SOBEL_PW-1:0] p;
    } sobel_win_t;

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line ring buffer for the Sobel window; asynchronous read taps, so reads see the old
// contents of the slot being written in the same cycle.
module sobel_line_buf #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] wr_ptr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] line1,
    output logic [DW-1:0] line2
);

    logic [DW-1:0] mem1 [IMG_W];
    logic [DW-1:0] mem2 [IMG_W];

    assign line1 = mem1[wr_ptr];
    assign line2 = mem2[wr_ptr];

    // Push the new pixel into line 1 and cascade the displaced pixel into line 2.
    always_ff @(posedge clk) begin
        if (en) begin
            mem1[wr_ptr] <= din;
            mem2[wr_ptr] <= mem1[wr_ptr];
        end
    end

endmodule

// File: rtl/sobel_edge_px.sv
// Sobel edge detector for multi-bit grayscale streams, fixed 4-clock latency, border masked.
// Optional build macro SOBEL_MAG_OUT_EN adds the registered gradient magnitude output dout_mag.
module sobel_edge_px
    import sobel_pkg::*;
#(
    parameter int DW         = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int THRESH_DEF = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          din_vld,
    input  logic          din_sop,
    input  logic          din_eop,
    input  logic [DW+2:0] thresh,
    output logic          dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop
`ifdef SOBEL_MAG_OUT_EN
    ,
    output logic [DW+2:0] dout_mag
`endif
);

    localparam int GW  = gw(DW);
    localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LAT = SOBEL_LAT;

    logic [CW-1:0]   col_cnt_q, col_cnt_d, cur_col_s;
    logic [RW-1:0]   row_cnt_q, row_cnt_d, cur_row_s;
    logic [GW-1:0]   thresh_q, thresh_d;
    logic            int_s;
    logic [DW-1:0]   line1_s, line2_s;
    sobel_win_t      win_q, win_d;

    logic [DW+1:0]   l_q, r_q, t_q, b_q, l_d, r_d, t_d, b_d;
    logic [DW+1:0]   gx_q, gy_q, gx_d, gy_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   thr1_q, thr2_q, thr3_q, thr1_d, thr2_d, thr3_d;
    logic            dout_q, dout_d;
    logic [LAT-1:0]  vld_q, sop_q, eop_q, vld_d, sop_d, eop_d;
    logic [LAT-2:0]  int_q, int_d;
`ifdef SOBEL_MAG_OUT_EN
    logic [GW-1:0]   mag_q, mag_d;
`endif

    function automatic logic [DW+1:0] csum(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [DW-1:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [DW+1:0] absdiff(input logic [DW+1:0] a,
                                               input logic [DW+1:0] b);
        logic [DW+1:0] res;
        if (a >= b) begin
            res = a - b;
        end else begin
            res = b - a;
        end
        return res;
    endfunction

    sobel_line_buf #(
        .DW    (DW),
        .IMG_W (IMG_W),
        .AW    (CW)
    ) u_line_buf (
        .clk    (clk),
        .en     (din_vld),
        .wr_ptr (cur_col_s),
        .din    (din),
        .line1  (line1_s),
        .line2  (line2_s)
    );

    // Position tracking: sop restarts the frame at (0,0) for the pixel carrying it.
    always_comb begin
        cur_col_s = din_sop ? {CW{1'b0}} : col_cnt_q;
        cur_row_s = din_sop ? {RW{1'b0}} : row_cnt_q;
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        thresh_d  = thresh_q;
        if (din_vld) begin
            if (cur_col_s == CW'(IMG_W - 1)) begin
                col_cnt_d = {CW{1'b0}};
                if (cur_row_s == RW'(IMG_H - 1)) begin
                    row_cnt_d = cur_row_s;
                end else begin
                    row_cnt_d = cur_row_s + RW'(1);
                end
            end else begin
                col_cnt_d = cur_col_s + CW'(1);
                row_cnt_d = cur_row_s;
            end
            if (din_sop) begin
                thresh_d = thresh;
            end else begin
                thresh_d = thresh_q;
            end
        end else begin
            col_cnt_d = col_cnt_q;
            row_cnt_d = row_cnt_q;
        end
        int_s = din_vld && (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    end

    // Window shift and the full arithmetic pipeline.
    always_comb begin
        win_d = win_q;
        if (din_vld) begin
            for (int k = 0; k < 3; k++) begin
                win_d.p[k][0] = win_q.p[k][1];
                win_d.p[k][1] = win_q.p[k][2];
            end
            win_d.p[0][2] = SOBEL_PW'(line2_s);
            win_d.p[1][2] = SOBEL_PW'(line1_s);
            win_d.p[2][2] = SOBEL_PW'(din);
        end else begin
            win_d = win_q;
        end

        l_d = csum(win_d.p[0][0][DW-1:0], win_d.p[1][0][DW-1:0], win_d.p[2][0][DW-1:0]);
        r_d = csum(win_d.p[0][2][DW-1:0], win_d.p[1][2][DW-1:0], win_d.p[2][2][DW-1:0]);
        t_d = csum(win_d.p[0][0][DW-1:0], win_d.p[0][1][DW-1:0], win_d.p[0][2][DW-1:0]);
        b_d = csum(win_d.p[2][0][DW-1:0], win_d.p[2][1][DW-1:0], win_d.p[2][2][DW-1:0]);

        gx_d = absdiff(r_q, l_q);
        gy_d = absdiff(b_q, t_q);
        g_d  = {1'b0, gx_q} + {1'b0, gy_q};

        // The threshold travels with each pixel so a sop in flight cannot retime the previous frame.
        thr1_d = (din_vld && din_sop) ? thresh : thresh_q;
        thr2_d = thr1_q;
        thr3_d = thr2_q;

        dout_d = int_q[LAT-2] & (g_q >= thr3_q);
`ifdef SOBEL_MAG_OUT_EN
        mag_d  = int_q[LAT-2] ? g_q : {GW{1'b0}};
`endif

        vld_d = {vld_q[LAT-2:0], din_vld};
        sop_d = {sop_q[LAT-2:0], din_vld & din_sop};
        eop_d = {eop_q[LAT-2:0], din_vld & din_eop};
        int_d = {int_q[LAT-3:0], int_s};
    end

    // State and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            thresh_q  <= GW'(THRESH_DEF);
            win_q     <= '0;
            l_q       <= '0;
            r_q       <= '0;
            t_q       <= '0;
            b_q       <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            g_q       <= '0;
            thr1_q    <= '0;
            thr2_q    <= '0;
            thr3_q    <= '0;
            dout_q    <= 1'b0;
            vld_q     <= '0;
            sop_q     <= '0;
            eop_q     <= '0;
            int_q     <= '0;
`ifdef SOBEL_MAG_OUT_EN
            mag_q     <= '0;
`endif
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            thresh_q  <= thresh_d;
            win_q     <= win_d;
            l_q       <= l_d;
            r_q       <= r_d;
            t_q       <= t_d;
            b_q       <= b_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            g_q       <= g_d;
            thr1_q    <= thr1_d;
            thr2_q    <= thr2_d;
            thr3_q    <= thr3_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
            sop_q     <= sop_d;
            eop_q     <= eop_d;
            int_q     <= int_d;
`ifdef SOBEL_MAG_OUT_EN
            mag_q     <= mag_d;
`endif
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q[LAT-1];
    assign dout_sop = sop_q[LAT-1];
    assign dout_eop = eop_q[LAT-1];
`ifdef SOBEL_MAG_OUT_EN
    assign dout_mag = mag_q;
`endif

endmodule

// File: doc/sobel_edge_px.md
Name: sobel_edge_px

Overview:
Parametrised Sobel edge detector for multi-bit grayscale pixel streams; successor to the 1-bit binary Sobel stage.
- Holds its own two-line buffer.
- Tracks row/column position and masks border pixels.
- Compares gradient magnitude against a per-frame threshold.
- Sits between the grayscale conversion stage and the display/frame-buffer writer, using the same vld/sop/eop stream protocol.

Parameters:
DW, 8, input pixel width in bits
IMG_W, 640, pixels per line (line buffer depth)
IMG_H, 480, lines per frame (row counter range only)
THRESH_DEF, 96, threshold value loaded at reset

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
din  in  DW  grayscale pixel
din_vld  in  1  pixel valid
din_sop  in  1  first pixel of frame, qualified by din_vld
din_eop  in  1  last pixel of frame, qualified by din_vld
thresh  in  DW+3  edge threshold, sampled at sop
dout  out  1  1 = edge (white), 0 = non-edge
dout_vld  out  1  output valid
dout_sop  out  1  output start of frame
dout_eop  out  1  output end of frame

Behaviour:
- Reset: dout, dout_vld, dout_sop and dout_eop are 0; all pipeline, window and counter registers are 0; thresh_q = THRESH_DEF. Line buffer RAM contents are not cleared.
- Window advance:
  - Line buffers and the 3x3 window shift only on din_vld.
  - Line buffers are a ring of IMG_W entries, with a write pointer equal to col_cnt.
- Counters:
  - col_cnt increments on each din_vld, wrapping from IMG_W-1 to 0 and then incrementing row_cnt.
  - row_cnt saturates at IMG_H-1.
  - din_vld&din_sop forces col_cnt=0 and row_cnt=0 for that pixel and loads thresh_q<=thresh.
  - A mid-frame sop restarts the counters in the same way.
- Pipeline: fixed latency of 4 clocks, with no stall.
  - dout_vld, dout_sop and dout_eop equal din_vld, din_sop and din_eop delayed by exactly 4 clocks.
  - Bubbles propagate unchanged, and output count equals input count.
- Arithmetic, for input pixel (r,c) with window rows r-2..r and cols c-2..c:
  - Stage 1: column sums L = p[r-2][c-2] + 2*p[r-1][c-2] + p[r][c-2], and R likewise on column c. Row sums T and B are formed the same way. Width DW+2.
  - Stage 2: gx = |R-L| and gy = |B-T|, computed by compare-then-subtract with no signed wrap. Width DW+2.
  - Stage 3: g = gx+gy, width DW+3; g never exceeds 8*(2^DW-1), so there is no overflow.
  - Stage 4: dout <= (g >= thresh_q) & interior. dout is registered.
- Border: interior = (row_cnt_at_input >= 2) && (col_cnt_at_input >= 2), carried through the pipeline alongside the data. Non-interior outputs are 0, which masks stale line-buffer data.
- din_eop carries no state effect beyond delay.
- thresh changes mid-frame are ignored until the next sop.
- Reset mid-frame: all outputs drop to 0 asynchronously. Pixels received before the first sop after reset are processed with counters starting at 0.

Optional Feature:
SOBEL_MAG_OUT_EN
- Defined: adds output port dout_mag [DW+2:0], reset 0. It is registered g, masked to 0 when not interior, and aligned with dout.
- Undefined: the port and its register are absent, and dout behaviour is identical in both builds.

Decomposition:
- sobel_pkg:
  - constant SOBEL_LAT=4.
  - function gw(DW)=DW+3 for the gradient width.
  - typedef of the 3x3 window struct.
- Sub-module sobel_line_buf:
  - IMG_W-deep, 2-line ring buffer with inputs clk, en, wr_ptr, din.
  - Tap outputs line1 and line2, read-before-write, inferred RAM.
- The top level holds the counters, window, arithmetic pipeline and delay lines.

Test Plan:
The bench uses DW=8, IMG_W=8, IMG_H=8, with a 64-pixel frame and continuous valid unless stated.
- Flat 100-valued frame, thresh=1 -> 64 dout_vld pulses, all dout=0; dout_sop exactly 4 clocks after din_sop; dout_eop on the 64th output.
- Vertical step (cols 0-3 = 0, cols 4-7 = 255), thresh=100:
  - Interior outputs at input col 4 or 5 (rows 2-7) -> g=1020, dout=1, 12 ones total.
  - All other outputs -> 0.
  - With the macro defined -> dout_mag=1020 at those outputs.
- Horizontal step (rows 0-3 = 0, rows 4-7 = 255), thresh=100 -> dout=1 only at input rows 4-5, cols 2-7 (12 ones).
- Vertical step with din_vld toggled 1,0,1,0 -> identical dout sequence to the vertical-step case; each dout_vld exactly 4 clocks after its din_vld.
- Threshold boundary on the vertical step:
  - thresh=1021 -> all 0; thresh=1020 -> 12 ones.
  - thresh changed to 2047 mid-frame -> current frame unchanged; next frame all 0.
- rst_n pulsed after 20 pixels -> all outputs 0 immediately and no pending dout_vld emerges; the next sop-led vertical-step frame gives exactly the 12 ones of the vertical-step case.
